div_wb_arb: RTL and testbench

DIV_WB_ARB -- requirements
Module: div_wb_arb

---
 rtl/div_wb_arb.sv | 137 +++++++++++++
 tb/tb_div_wb_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/div_wb_arb.sv
// Divide write-back arbiter: buffers divide results in a small FIFO and shares one GPR write port with loads.
// Optional same-cycle bypass of an empty buffer is enabled by defining DIV_WB_BYPASS_EN.
module div_wb_arb #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_div_finish,
  input  logic [XLEN-1:0] exu_div_result,
  input  logic [4:0]      div_rd,
  input  logic            div_cancel,
  input  logic            ld_wen,
  input  logic [4:0]      ld_waddr,
  input  logic [XLEN-1:0] ld_wdata,
  input  logic [4:0]      query_rd,
  output logic            gpr_wen,
  output logic [4:0]      gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            div_wb_full,
  output logic            query_hit,
  output logic            div_wb_ovf
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  logic fifo_empty, fifo_full, push_req, push, pop, bypass;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    // A finish in a cancel cycle belongs to the flushed stream and is discarded.
    push_req   = exu_div_finish && (div_rd != 5'd0) && !div_cancel;
    pop        = !ld_wen && !fifo_empty;
`ifdef DIV_WB_BYPASS_EN
    bypass     = push_req && fifo_empty && !ld_wen;
`else
    bypass     = 1'b0;
`endif
    // A same-cycle pop frees the slot the new result lands in.
    push       = push_req && !bypass && (!fifo_full || pop);
    ovf_d      = ovf_q || (push_req && !bypass && fifo_full && !pop);

    valid_d  = valid_q;
    rd_d     = rd_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]    = div_rd;
      data_d[wr_ptr_q]  = exu_div_result;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (div_cancel) begin
      valid_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Loads always win the port; otherwise the FIFO head, otherwise a bypassed result.
  always_comb begin
    gpr_wen   = 1'b0;
    gpr_waddr = 5'd0;
    gpr_wdata = '0;
    if (ld_wen) begin
      gpr_wen   = 1'b1;
      gpr_waddr = ld_waddr;
      gpr_wdata = ld_wdata;
    end else if (pop) begin
      gpr_wen   = 1'b1;
      gpr_waddr = rd_q[rd_ptr_q];
      gpr_wdata = data_q[rd_ptr_q];
    end else if (bypass) begin
      gpr_wen   = 1'b1;
      gpr_waddr = div_rd;
      gpr_wdata = exu_div_result;
    end
  end

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_q[i] == query_rd) && (query_rd != 5'd0)) query_hit = 1'b1;
    end
  end

  assign div_wb_full = fifo_full;
  assign div_wb_ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_div_wb_arb.sv
// Randomized and directed bench for div_wb_arb against a queue-based model of the write-back buffer.
module tb_div_wb_arb;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            exu_div_finish = 1'b0;
  logic [XLEN-1:0] exu_div_result = '0;
  logic [4:0]      div_rd = '0;
  logic            div_cancel = 1'b0;
  logic            ld_wen = 1'b0;
  logic [4:0]      ld_waddr = '0;
  logic [XLEN-1:0] ld_wdata = '0;
  logic [4:0]      query_rd = '0;
  logic            gpr_wen;
  logic [4:0]      gpr_waddr;
  logic [XLEN-1:0] gpr_wdata;
  logic            div_wb_full;
  logic            query_hit;
  logic            div_wb_ovf;

  int checks   = 0;
  int failures = 0;

  logic [XLEN+4:0] exp_q[$];
  logic            exp_ovf = 1'b0;

  div_wb_arb #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .exu_div_finish(exu_div_finish), .exu_div_result(exu_div_result), .div_rd(div_rd),
    .div_cancel(div_cancel), .ld_wen(ld_wen), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .query_rd(query_rd), .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .div_wb_full(div_wb_full), .query_hit(query_hit), .div_wb_ovf(div_wb_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic fin, input logic [4:0] rd, input logic [XLEN-1:0] data,
                       input logic cancel, input logic ldw, input logic [4:0] la,
                       input logic [XLEN-1:0] ld, input logic [4:0] q);
    exu_div_finish = fin;
    div_rd         = rd;
    exu_div_result = data;
    div_cancel     = cancel;
    ld_wen         = ldw;
    ld_waddr       = la;
    ld_wdata       = ld;
    query_rd       = q;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, '0, 5'd0);
  endtask

  // Checks the outputs for the currently driven inputs, then advances one clock and updates the model.
  task automatic tick();
    logic            byp;
    logic            valid_res;
    logic            e_wen;
    logic [4:0]      e_addr;
    logic [XLEN-1:0] e_data;
    logic            e_hit;
    #1;
    valid_res = exu_div_finish && (div_rd != 5'd0) && !div_cancel;
    byp = 1'b0;
`ifdef DIV_WB_BYPASS_EN
    byp = valid_res && !ld_wen && (exp_q.size() == 0);
`endif
    e_wen = 1'b0; e_addr = 5'd0; e_data = '0;
    if (ld_wen) begin
      e_wen = 1'b1; e_addr = ld_waddr; e_data = ld_wdata;
    end else if (exp_q.size() > 0) begin
      e_wen = 1'b1; e_addr = exp_q[0][XLEN+4:XLEN]; e_data = exp_q[0][XLEN-1:0];
    end else if (byp) begin
      e_wen = 1'b1; e_addr = div_rd; e_data = exu_div_result;
    end
    e_hit = 1'b0;
    foreach (exp_q[i]) if (query_rd != 5'd0 && exp_q[i][XLEN+4:XLEN] == query_rd) e_hit = 1'b1;
    check("gpr_wen", 64'(gpr_wen), 64'(e_wen));
    check("gpr_waddr", 64'(gpr_waddr), 64'(e_addr));
    check("gpr_wdata", 64'(gpr_wdata), 64'(e_data));
    check("div_wb_full", 64'(div_wb_full), 64'(exp_q.size() == DEPTH));
    check("query_hit", 64'(query_hit), 64'(e_hit));
    check("div_wb_ovf", 64'(div_wb_ovf), 64'(exp_ovf));
    @(posedge clk);
    if (!ld_wen && exp_q.size() > 0) void'(exp_q.pop_front());
    if (valid_res && !byp) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({div_rd, exu_div_result});
      else exp_ovf = 1'b1;
    end
    if (div_cancel) exp_q.delete();
    @(negedge clk);
  endtask

  // Reset with random traffic on the inputs to show reset overrides it.
  task automatic do_reset();
    drive(1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)),
          1'b0, 5'($urandom_range(0, 31)), $urandom, 5'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    idle();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    tick();

    // single divide rd=5, 0x100/2
    drive(1'b1, 5'd5, 32'h80, 1'b0, 1'b0, 5'd0, '0, 5'd0); tick();
    idle(); tick(); tick();

    // load collision
    drive(1'b1, 5'd3, 32'h1234, 1'b0, 1'b1, 5'd9, 32'hAAAA, 5'd3); tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b1, 5'd10, 32'hBBBB, 5'd3); tick();
    idle(); tick(); tick();

    // fill and overflow with loads held
    drive(1'b1, 5'd1, 32'h11, 1'b0, 1'b1, 5'd20, 32'hC0, 5'd1); tick();
    drive(1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 5'd21, 32'hC1, 5'd2); tick();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 5'd22, 32'hC2, 5'd4); tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b1, 5'd23, 32'hC3, 5'd4); tick();
    idle(); tick(); tick(); tick();

    // cancel with loads active
    drive(1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 5'd11, 32'hD0, 5'd6); tick();
    drive(1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 5'd12, 32'hD1, 5'd8); tick();
    drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 5'd13, 32'hD2, 5'd6); tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, '0, 5'd6); tick();

    // scoreboard lookup and x0
    drive(1'b1, 5'd7, 32'h77, 1'b0, 1'b1, 5'd14, 32'hE0, 5'd7); tick();
    drive(1'b1, 5'd0, 32'hFF, 1'b0, 1'b1, 5'd15, 32'hE1, 5'd7); tick();
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, '0, 5'd0); tick(); tick();
    drive(1'b1, 5'd0, 32'hFE, 1'b0, 1'b0, 5'd0, '0, 5'd0); tick();
    idle(); tick();

    // reset mid-operation with a buffered entry and overflow set
    drive(1'b1, 5'd1, 32'h1, 1'b0, 1'b1, 5'd2, 32'h2, 5'd0); tick();
    drive(1'b1, 5'd2, 32'h2, 1'b0, 1'b1, 5'd2, 32'h2, 5'd0); tick();
    drive(1'b1, 5'd3, 32'h3, 1'b0, 1'b1, 5'd2, 32'h2, 5'd1); tick();
    do_reset();
    tick(); tick();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] qrd;
      qrd = (exp_q.size() > 0 && $urandom_range(0, 1) == 1) ? exp_q[0][XLEN+4:XLEN]
                                                            : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
            $urandom, 1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 50),
            5'($urandom_range(0, 31)), $urandom, qrd);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end
    idle(); tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
